// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants for the memory responder: access direction encodings,
//   the default line width and the 2-bit FSM state encodings.
package mem_responder_pkg;

    localparam logic       MEM_READ    = 1'b0;
    localparam logic       MEM_WRITE   = 1'b1;

    localparam int         BWIDTH_DEF  = 128;

    localparam logic [1:0] MEM_IDLE    = 2'd0;
    localparam logic [1:0] MEM_BUSY    = 2'd1;
    localparam logic [1:0] MEM_ACK     = 2'd2;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   Single-port synchronous RAM, DEPTH lines of BWIDTH bits. Not reset.
//   Ports:
//     clk   - clock, rising edge
//     we    - write enable; wdata is written to line idx at the edge
//     idx   - line index, used for both the write and the read
//     wdata - write data
//     rdata - registered read data (read-before-write of line idx)
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int BWIDTH = BWIDTH_DEF,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [BWIDTH-1:0]        wdata,
    output logic [BWIDTH-1:0]        rdata
);

    logic [BWIDTH-1:0] mem [DEPTH];
    logic [BWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU memory port. Serves one line-wide read
//   or write per request, acknowledged LATENCY edges after acceptance, using
//   a 4-phase enable/ack handshake.
//   Handshake: the CPU raises mem_enable with mem_rw/mem_addr/mem_data_in and
//   holds it until mem_ack=1; the request is latched on the first edge that
//   sees mem_enable=1 in IDLE. mem_ack stays high until an edge samples
//   mem_enable=0. Dropping mem_enable before ack aborts the request.
//   Ports:
//     clk, reset      - clock (rising edge), asynchronous active-low reset
//     mem_enable      - request valid / held high until ack
//     mem_rw          - 0 read, 1 write (sampled at acceptance)
//     mem_addr        - byte address (sampled at acceptance)
//     mem_data_in     - write data (sampled at acceptance)
//     mem_data_out    - last read data, meaningful while mem_ack=1 after a read
//     mem_ack         - request complete (registered, Moore)
//     dbg_state       - current FSM state for observation
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int BWIDTH     = BWIDTH_DEF,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BWIDTH-1:0]     mem_data_in,
    output logic [BWIDTH-1:0]     mem_data_out,
    output logic                  mem_ack,
    output logic [1:0]            dbg_state
);

    localparam int OFS = $clog2(BWIDTH / 8);
    localparam int IDX = $clog2(DEPTH);
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [IDX-1:0]    idx_q, idx_d;
    logic [BWIDTH-1:0] wdata_q, wdata_d;
    logic [BWIDTH-1:0] dout_q, dout_d;
    logic              ack_q, ack_d;

    logic [IDX-1:0]    addr_idx;
    logic [IDX-1:0]    arr_idx;
    logic              arr_we;
    logic [BWIDTH-1:0] arr_rdata;

    // Byte offset and upper address bits do not select a line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFS+IDX], mem_addr[OFS-1:0]};

    assign addr_idx = mem_addr[OFS+IDX-1:OFS];

    // The RAM read is registered, so its address runs one cycle ahead of the
    // access edge: the live request index while idle (covers LATENCY=1), the
    // latched index afterwards. Nothing writes the array between that read
    // and the access edge, so rdata is current when it is captured.
    assign arr_idx = (state_q == MEM_IDLE) ? addr_idx : idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        arr_we  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_enable) begin
                    rw_d    = mem_rw;
                    idx_d   = addr_idx;
                    wdata_d = mem_data_in;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (!mem_enable) begin
                    state_d = MEM_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = MEM_ACK;
                    if (rw_q == MEM_WRITE) begin
                        arr_we = 1'b1;
                    end else begin
                        dout_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MEM_ACK: begin
                if (!mem_enable) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        ack_d = (state_d == MEM_ACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            rw_q    <= MEM_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
        end
    end

    mem_array #(
        .BWIDTH (BWIDTH),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mem_data_out = dout_q;
    assign mem_ack      = ack_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Two responders share clock and reset: index 0 uses LATENCY=5, index 1
//   uses LATENCY=1. Driver tasks issue requests and push the expected
//   mem_data_out at ack into a per-DUT queue; a monitor pops and compares on
//   every rising mem_ack.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int W = 128;

    logic          clk;
    logic          reset;
    logic          en    [2];
    logic          rw    [2];
    logic [31:0]   addr  [2];
    logic [W-1:0]  din   [2];
    logic [W-1:0]  dout  [2];
    logic          ack   [2];
    logic [1:0]    st    [2];
    logic          ack_prev [2];

    logic [W-1:0]  exp_q0[$];
    logic [W-1:0]  exp_q1[$];
    logic [W-1:0]  last_rd [2];

    int checks = 0;
    int errors = 0;

    mem_responder #(.BWIDTH(W), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(5)) dut5 (
        .clk(clk), .reset(reset), .mem_enable(en[0]), .mem_rw(rw[0]),
        .mem_addr(addr[0]), .mem_data_in(din[0]), .mem_data_out(dout[0]),
        .mem_ack(ack[0]), .dbg_state(st[0])
    );

    mem_responder #(.BWIDTH(W), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_enable(en[1]), .mem_rw(rw[1]),
        .mem_addr(addr[1]), .mem_data_in(din[1]), .mem_data_out(dout[1]),
        .mem_ack(ack[1]), .dbg_state(st[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && !ack_prev[d]) begin
                logic [W-1:0] e;
                logic         have;
                have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_ack dut%0d: ack=1 with no request outstanding", d);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    checks++;
                    if (dout[d] !== e) begin
                        errors++;
                        $display("FAIL data_at_ack dut%0d: got %h expected %h", d, dout[d], e);
                    end
                end
            end
            ack_prev[d] <= ack[d];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs(input int d);
        en[d]   = 1'b0;
        rw[d]   = MEM_READ;
        addr[d] = '0;
        din[d]  = '0;
    endtask

    // One full handshake. For reads exp_rd is the expected line contents;
    // for writes mem_data_out must keep the last read value.
    task automatic do_req(input int d, input logic rw_i, input logic [31:0] a,
                          input logic [W-1:0] wd, input logic [W-1:0] exp_rd,
                          input int hold);
        int lat;
        int n;
        lat = (d == 0) ? 5 : 1;
        @(negedge clk);
        if (rw_i == MEM_READ) last_rd[d] = exp_rd;
        if (d == 0) exp_q0.push_back(last_rd[d]); else exp_q1.push_back(last_rd[d]);
        en[d] = 1'b1; rw[d] = rw_i; addr[d] = a; din[d] = wd;
        @(posedge clk);  // acceptance edge
        #1;
        // Post-acceptance changes must be ignored.
        addr[d] = ~a; din[d] = ~wd; rw[d] = ~rw_i;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ack[d]) begin
                n = i;
                break;
            end
        end
        check($sformatf("latency dut%0d addr %h", d, a), W'(n), W'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ack_held dut%0d", d), W'(ack[d]), W'(1));
        end
        @(negedge clk);
        en[d] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("ack_drop dut%0d", d), W'(ack[d]), W'(0));
        check($sformatf("idle_after dut%0d", d), W'(st[d]), W'(MEM_IDLE));
    endtask

    task automatic do_abort(input int d, input logic [31:0] a, input logic [W-1:0] wd);
        @(negedge clk);
        en[d] = 1'b1; rw[d] = MEM_WRITE; addr[d] = a; din[d] = wd;
        @(posedge clk);  // edge 0
        @(posedge clk);  // edge 1
        @(posedge clk);  // edge 2
        @(negedge clk);
        en[d] = 1'b0;    // sampled low at edge 3
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", W'(ack[d]), W'(0));
        end
        check("abort_idle", W'(st[d]), W'(MEM_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [W-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [W-1:0] DA = {16{8'hAA}};
    localparam logic [W-1:0] D5 = {16{8'h55}};
    localparam logic [W-1:0] D3 = {16{8'h33}};
    localparam logic [W-1:0] X1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [W-1:0] X2 = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
    localparam logic [W-1:0] H1 = 128'h11112222333344445555666677778888;
    localparam logic [W-1:0] L1 = 128'hFEDCBA98765432100011223344556677;

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            last_rd[d] = '0;
            ack_prev[d] = 1'b0;
        end
        reset = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        rw[0] = MEM_WRITE; addr[0] = 32'h40; din[0] = D1;
        rw[1] = MEM_WRITE; addr[1] = 32'h40; din[1] = D1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check("reset_ack", W'(ack[d]), W'(0));
                check("reset_dout", dout[d], '0);
                check("reset_state", W'(st[d]), W'(MEM_IDLE));
            end
        end
        @(negedge clk);
        idle_inputs(0); idle_inputs(1);
        reset = 1'b1;

        // Write then read, hold enable on the read.
        do_req(0, MEM_WRITE, 32'h40, D1, '0, 0);
        do_req(0, MEM_READ,  32'h40, '0, D1, 4);

        // Alignment / wrap: 0x1000 is line 0.
        do_req(0, MEM_WRITE, 32'h1000, DA, '0, 0);
        do_req(0, MEM_READ,  32'h0000, '0, DA, 0);
        do_req(0, MEM_READ,  32'h000F, '0, DA, 0);

        // Abort leaves the old contents.
        do_req(0, MEM_WRITE, 32'h80, D3, '0, 0);
        do_abort(0, 32'h80, D5);
        do_req(0, MEM_READ,  32'h80, '0, D3, 0);

        // Held enable on a write: single commit, neighbour line untouched.
        do_req(0, MEM_WRITE, 32'h300, H1, '0, 4);
        do_req(0, MEM_READ,  32'h300, '0, H1, 0);
        do_req(0, MEM_READ,  32'h40,  '0, D1, 0);

        // Mid-request reset drops a pending write.
        do_req(0, MEM_WRITE, 32'h200, X1, '0, 0);
        do_req(0, MEM_READ,  32'h200, '0, X1, 0);
        @(negedge clk);
        en[0] = 1'b1; rw[0] = MEM_WRITE; addr[0] = 32'h200; din[0] = X2;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_ack", W'(ack[0]), W'(0));
        check("midreset_state", W'(st[0]), W'(MEM_IDLE));
        check("midreset_dout", dout[0], '0);
        last_rd[0] = '0; last_rd[1] = '0;
        idle_inputs(0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_ack", W'(ack[0]), W'(0));
        end
        do_req(0, MEM_READ, 32'h200, '0, X1, 0);

        // LATENCY=1 instance.
        do_req(1, MEM_WRITE, 32'h40, L1, '0, 0);
        do_req(1, MEM_READ,  32'h40, '0, L1, 2);
        do_req(1, MEM_WRITE, 32'h1010, DA, '0, 0);
        do_req(1, MEM_READ,  32'h0010, '0, DA, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL missing_ack: outstanding %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
